// File: rtl/spi_req_scheduler_pkg.sv
// Shared types and helpers for the SPI request scheduler: FSM state encoding,
// width-field size and the transfer-width legality check.
package spi_sched_pkg;

  localparam int WIDTH_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARMED  = 3'd2,
    BUSY   = 3'd3,
    GAP    = 3'd4
  } stateT;

  // A zero-length or over-long word cannot be shifted; such requests are rejected.
  function automatic logic widthLegal(input logic [WIDTH_W-1:0] width, input int maxWidth);
    return (width != '0) && (int'(width) <= maxWidth);
  endfunction

endpackage

// File: rtl/spi_req_scheduler_if.sv
// Request/shifter bundle for spi_req_scheduler. The scheduler uses the slave
// modport; requesters and the shifter (or a bench) use the master modport.
interface spi_req_scheduler_if #(
  parameter int NREQ     = 4,
  parameter int MAXWIDTH = 128
) ();
  import spi_sched_pkg::*;

  logic [NREQ-1:0]          iReqValid;
  logic [NREQ*MAXWIDTH-1:0] iReqData;
  logic [NREQ*WIDTH_W-1:0]  iReqWidth;
  logic [NREQ-1:0]          oReqAck;
  logic                     oReqErr;
  logic [NREQ-1:0]          oGrant;
  logic                     oSpiTrig;
  logic [MAXWIDTH-1:0]      oSpiData;
  logic [WIDTH_W-1:0]       oSpiWidth;
  logic                     iSpiReady;
  logic                     oBusy;

  modport slave (
    input  iReqValid, iReqData, iReqWidth, iSpiReady,
    output oReqAck, oReqErr, oGrant, oSpiTrig, oSpiData, oSpiWidth, oBusy
  );

  modport master (
    output iReqValid, iReqData, iReqWidth, iSpiReady,
    input  oReqAck, oReqErr, oGrant, oSpiTrig, oSpiData, oSpiWidth, oBusy
  );

endinterface

// File: rtl/spi_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick of the first valid request at
// or after the pointer; the pointer moves past the winner when iAdvance is set.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic [NREQ-1:0]         iValid,
  input  logic                    iAdvance,
  output logic [NREQ-1:0]         oPick,
  output logic [$clog2(NREQ)-1:0] oPickIdx,
  output logic                    oAny
);
  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int idx;
    idx      = 0;
    oPick    = '0;
    oPickIdx = '0;
    oAny     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!oAny && iValid[IDX_W'(idx)]) begin
        oAny                = 1'b1;
        oPick[IDX_W'(idx)]  = 1'b1;
        oPickIdx            = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ptr <= '0;
    end else if (iAdvance) begin
      ptr <= (int'(oPickIdx) == NREQ - 1) ? '0 : oPickIdx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spi_req_scheduler.sv
// Shares one SingleSPI-family shifter between NREQ requesters with round-robin
// arbitration and a CS-high gap. Optional watchdog: define SPI_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a request while the shifter reports ready
// LAUNCH | one-cycle trigger pulse to the shifter
// ARMED  | waiting for the shifter to drop ready (transfer accepted)
// BUSY   | transfer in progress, waiting for ready to return
// GAP    | enforced idle time before the next grant
module spi_req_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAXWIDTH = 128,
  parameter int GAPCYC   = 2,
  parameter int TIMEOUT  = 1023
) (
  input logic                iClk,
  input logic                iRstN,
  spi_req_scheduler_if.slave bus
);
  localparam int         IDX_W      = $clog2(NREQ);
  localparam logic [3:0] GAP_LOAD   = (GAPCYC > 0) ? 4'(GAPCYC - 1) : 4'd0;
  localparam stateT      AFTER_DONE = (GAPCYC == 0) ? IDLE : GAP;

  stateT               state, stateNxt;
  logic [NREQ-1:0]     reqMasked, pick, grant, ack, ackNxt;
  logic [IDX_W-1:0]    pickIdx;
  logic                anyValid, advance, capture, grantSet, finish;
  logic                err, errNxt, timeoutHit;
  logic [MAXWIDTH-1:0] spiData, selData;
  logic [WIDTH_W-1:0]  spiWidth, selWidth;
  logic [3:0]          gapCnt;

  // A requester being acked this cycle may not have dropped valid yet.
  assign reqMasked = bus.iReqValid & ~ack;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iValid   (reqMasked),
    .iAdvance (advance),
    .oPick    (pick),
    .oPickIdx (pickIdx),
    .oAny     (anyValid)
  );

  assign selData  = bus.iReqData[int'(pickIdx)*MAXWIDTH +: MAXWIDTH];
  assign selWidth = bus.iReqWidth[int'(pickIdx)*WIDTH_W +: WIDTH_W];

`ifdef SPI_TIMEOUT_EN
  logic [9:0] wdCnt;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wdCnt <= '0;
    end else if ((stateNxt != state) || !(state inside {ARMED, BUSY})) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + 10'd1;
    end
  end

  assign timeoutHit = (wdCnt == 10'(TIMEOUT - 1));
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
  assign timeoutHit    = 1'b0;
`endif

  always_comb begin
    stateNxt = state;
    advance  = 1'b0;
    capture  = 1'b0;
    grantSet = 1'b0;
    finish   = 1'b0;
    ackNxt   = '0;
    errNxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iSpiReady && anyValid) begin
          advance = 1'b1;
          capture = 1'b1;
          if (widthLegal(selWidth, MAXWIDTH)) begin
            grantSet = 1'b1;
            stateNxt = LAUNCH;
          end else begin
            ackNxt = pick;
            errNxt = 1'b1;
          end
        end
      end
      LAUNCH: stateNxt = ARMED;
      ARMED: begin
        if (!bus.iSpiReady) begin
          stateNxt = BUSY;
        end else if (timeoutHit) begin
          finish   = 1'b1;
          ackNxt   = grant;
          errNxt   = 1'b1;
          stateNxt = AFTER_DONE;
        end
      end
      BUSY: begin
        if (bus.iSpiReady) begin
          finish   = 1'b1;
          ackNxt   = grant;
          stateNxt = AFTER_DONE;
        end else if (timeoutHit) begin
          finish   = 1'b1;
          ackNxt   = grant;
          errNxt   = 1'b1;
          stateNxt = AFTER_DONE;
        end
      end
      GAP: begin
        if (gapCnt == 4'd0) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNxt;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      spiData  <= '0;
      spiWidth <= '0;
      gapCnt   <= '0;
    end else begin
      ack <= ackNxt;
      err <= errNxt;
      // Word stays frozen outside IDLE since the shifter reloads it while idle.
      if (capture) begin
        spiData  <= selData;
        spiWidth <= selWidth;
      end
      if (grantSet)    grant <= pick;
      else if (finish) grant <= '0;
      if (finish)                             gapCnt <= GAP_LOAD;
      else if (state == GAP && gapCnt != '0)  gapCnt <= gapCnt - 4'd1;
    end
  end

  assign bus.oReqAck   = ack;
  assign bus.oReqErr   = err;
  assign bus.oGrant    = grant;
  assign bus.oSpiTrig  = (state == LAUNCH);
  assign bus.oSpiData  = spiData;
  assign bus.oSpiWidth = spiWidth;
  assign bus.oBusy     = (state != IDLE);

endmodule
